demux_8_stream: RTL and testbench
=================================

Name: demux_8_stream

Overview:
- Registered 1-to-8 demultiplexer: the write-side counterpart of the 8-way 32-bit select mux.
- Accepts one 32-bit word per cycle with a 3-bit destination select over a valid/ready handshake, and delivers it to one of 8 output lanes.
- Each output lane has its own one-entry holding register and valid/ready handshake.
- Used to fan a single producer out to eight independent consumers, e.g. per-unit writeback ports, without combinational paths from input data to outputs.

Parameters:
- WIDTH, 32, data width of each word and each lane.
- LANES, 8, number of output lanes; fixed at 8 (select is 3 bits).
- SEL_W, 3, select width, equal to log2(LANES).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can take a word for the lane named by in_select.
- in_select  input  3  destination lane 0..7.
- in_data  input  32  word to deliver.
- out_valid  output  8  bit i = lane i holds a word.
- out_ready  input  8  bit i = consumer i takes lane i's word this cycle.
- out_data  output  256  lane i word at bits [32*i+31 : 32*i].
- occupancy  output  4  count of set out_valid bits, 0..8.
- busy  output  1  OR of out_valid.

Behaviour:
- Reset (reset=0, asynchronous): all out_valid=0, out_data=0, occupancy=0, busy=0. Effect is immediate, not at the next edge. Any word in flight is discarded.
- in_ready is combinational: in_ready = !out_valid[in_select] | out_ready[in_select]. This is independent of in_valid.
- Accept occurs when in_valid & in_ready at a rising edge. At that edge lane in_select loads in_data and sets out_valid[in_select]=1.
  - Latency is one cycle: the word is visible on out_data in the cycle after acceptance.
- Drain occurs when out_valid[i] & out_ready[i] at an edge. Lane i clears out_valid[i]; out_data lane i holds its last value and is don't-care for checking.
- Simultaneous drain and accept on the same lane: the drain completes, the new word loads, and out_valid stays 1. Throughput is 1 word/cycle per lane when the consumer is always ready.
- Accepts and drains on different lanes in the same cycle are independent.
- Lane full and out_ready[sel]=0: in_ready=0. The producer must hold in_valid, in_select and in_data stable until accepted. The block captures nothing while in_ready=0.
- Other lanes keep draining while the selected lane is stalled. There is no reordering across lanes; per-lane order is strict FIFO (depth 1).
- out_ready on a lane with out_valid=0 has no effect.
- occupancy and busy are registered and updated at the same edge as out_valid, so they always equal popcount(out_valid) and |out_valid.
- occupancy boundaries:
  - 8 with all out_ready=0 gives in_ready=0 for every select.
  - 0 gives busy=0.
- in_select is sampled only when in_valid=1. X on in_select with in_valid=0 must not affect state.
- Reset released mid-stream: first accept possible at the first edge with reset=1.

Decomposition:
- Shared package: WIDTH=32, LANES=8, SEL_W=3 constants, plus a lane-index helper (lane i slice base = 32*i).
- Sub-module demux_lane: one-entry register with load, drain, valid and data. The top level is the select decoder and 8 demux_lane instances plus a popcount.

Test Plan:
- Reset mid-operation: fill lanes 2 and 5, pull reset=0 between edges -> out_valid=8'h00, occupancy=0, busy=0 immediately. In the first cycle after release, in_ready=1 for every select.
- Single word: send sel=3, data=32'hDEADBEEF with out_ready=0 -> next cycle out_valid=8'h08, out_data[127:96]=32'hDEADBEEF, occupancy=1, busy=1.
- Backpressure: lane 3 full with out_ready[3]=0, present sel=3, data=32'h12345678 -> in_ready=0 and lane 3 keeps 32'hDEADBEEF. Set out_ready[3]=1 -> accept at that edge, lane 3 holds 32'h12345678 and out_valid[3] stays 1.
- Streaming: out_ready=8'hFF, send data 1..16 to sel=7 back-to-back -> in_ready=1 every cycle and lane 7 shows 1..16 on consecutive cycles.
- Fill all lanes: sels 0..7 with data 32'h100+i and out_ready=0 -> occupancy=8 and in_ready=0 for all selects. Drain lane 4 -> occupancy=7, and in_ready=1 only when in_select=4.
- Cross-lane: accept to lane 1 while lane 6 drains in the same cycle -> out_valid[1]=1, out_valid[6]=0, occupancy unchanged.

Source files
------------

// File: rtl/demux_8_stream_pkg.sv
// ---------------------------------------------------------------------------
// demux_8_stream_pkg
// Shared constants and helpers for the 1-to-8 registered stream demux.
//   WIDTH  : data width of the input word and of every output lane
//   LANES  : number of output lanes (fixed at 8)
//   SEL_W  : lane select width, log2(LANES)
//   OCC_W  : width of the occupancy count (must hold 0..LANES)
// Helpers:
//   lane_base(i) : bit offset of lane i inside the packed lane data bus
//   popcount(v)  : number of set bits in a lane valid vector
// ---------------------------------------------------------------------------
package demux_8_stream_pkg;

   localparam int WIDTH = 32;
   localparam int LANES = 8;
   localparam int SEL_W = 3;
   localparam int OCC_W = 4;

   function automatic int lane_base(input int lane);
      return lane * WIDTH;
   endfunction

   function automatic logic [OCC_W-1:0] popcount(input logic [LANES-1:0] v);
      logic [OCC_W-1:0] n;
      n = '0;
      for (int i = 0; i < LANES; i++) begin
         n = n + OCC_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/demux_8_stream_if.sv
// ---------------------------------------------------------------------------
// demux_8_stream_if
// Bundles the producer handshake and the eight consumer handshakes.
//   in_valid / in_ready / in_select / in_data : producer side
//   out_valid / out_ready / out_data          : one valid/ready pair per lane,
//                                               lane i data at [32*i +: 32]
//   occupancy / busy                          : lane fill status
// Modports:
//   master : the environment (drives producer inputs and consumer readies)
//   slave  : the demux itself
// ---------------------------------------------------------------------------
interface demux_8_stream_if;
   import demux_8_stream_pkg::*;

   logic                   in_valid;
   logic                   in_ready;
   logic [SEL_W-1:0]       in_select;
   logic [WIDTH-1:0]       in_data;
   logic [LANES-1:0]       out_valid;
   logic [LANES-1:0]       out_ready;
   logic [LANES*WIDTH-1:0] out_data;
   logic [OCC_W-1:0]       occupancy;
   logic                   busy;

   modport master (
      output in_valid, in_select, in_data, out_ready,
      input  in_ready, out_valid, out_data, occupancy, busy
   );

   modport slave (
      input  in_valid, in_select, in_data, out_ready,
      output in_ready, out_valid, out_data, occupancy, busy
   );

endinterface

// File: rtl/demux_8_stream_lane.sv
// ---------------------------------------------------------------------------
// demux_lane
// One-entry holding register for a single output lane.
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset
//   load     : take data_in this edge (already qualified by the handshake)
//   drain    : consumer ready for this lane
//   data_in  : word to capture
//   vld_p1   : lane holds a word
//   vld_next : value vld_p1 takes at the next edge (feeds the occupancy count)
//   data_p1  : held word; keeps its last value after a drain
// ---------------------------------------------------------------------------
module demux_lane
   import demux_8_stream_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             drain,
   input  logic [WIDTH-1:0] data_in,
   output logic             vld_p1,
   output logic             vld_next,
   output logic [WIDTH-1:0] data_p1
);

   // A load on a draining lane wins, so a lane with an always-ready consumer
   // sustains one word per cycle without dropping valid.
   assign vld_next = load | (vld_p1 & ~drain);

   // Stage p1: lane holding register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
      end else begin
         vld_p1 <= vld_next;
         if (load) begin
            data_p1 <= data_in;
         end
      end
   end

endmodule

// File: rtl/demux_8_stream.sv
// ---------------------------------------------------------------------------
// demux_8_stream
// Registered 1-to-8 demultiplexer. One 32-bit word per cycle is steered by
// in_select into one of eight one-entry lane registers, each with its own
// valid/ready handshake towards an independent consumer. No combinational
// path exists from in_data to any output.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset; clears all lanes immediately
//   bus   : demux_8_stream_if.slave
//           in_valid/in_ready/in_select/in_data  producer handshake
//           out_valid/out_ready/out_data         per-lane consumer handshakes
//           occupancy                            number of full lanes (0..8)
//           busy                                 any lane full
// ---------------------------------------------------------------------------
module demux_8_stream
   import demux_8_stream_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   demux_8_stream_if.slave bus
);

   logic [LANES-1:0] vld_p1;
   logic [LANES-1:0] vld_next;
   logic [LANES-1:0] load;
   logic             in_ready;
   logic             accept;
   logic [WIDTH-1:0] lane_data [LANES];
   logic [OCC_W-1:0] occ_p1;
   logic             busy_p1;

   // The selected lane can take a word if it is empty or is being drained in
   // the same cycle. in_valid is deliberately not part of this term.
   assign in_ready = ~vld_p1[bus.in_select] | bus.out_ready[bus.in_select];
   assign accept   = bus.in_valid & in_ready;

   // in_select only matters once the transfer is qualified by in_valid, so an
   // undefined select while idle cannot reach any lane.
   always_comb begin
      load = '0;
      if (accept) begin
         load[bus.in_select] = 1'b1;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      demux_lane u_lane (
         .clock    (clock),
         .reset    (reset),
         .load     (load[i]),
         .drain    (bus.out_ready[i]),
         .data_in  (bus.in_data),
         .vld_p1   (vld_p1[i]),
         .vld_next (vld_next[i]),
         .data_p1  (lane_data[i])
      );
   end

   always_comb begin
      bus.out_data = '0;
      for (int i = 0; i < LANES; i++) begin
         bus.out_data[lane_base(i) +: WIDTH] = lane_data[i];
      end
   end

   // Stage p1: status registers, computed from the next lane state so they
   // change on the same edge as out_valid.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         occ_p1  <= '0;
         busy_p1 <= 1'b0;
      end else begin
         occ_p1  <= popcount(vld_next);
         busy_p1 <= |vld_next;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = vld_p1;
   assign bus.occupancy = occ_p1;
   assign bus.busy      = busy_p1;

endmodule

// File: tb/tb_demux_8_stream.sv
// ---------------------------------------------------------------------------
// tb_demux_8_stream
// Scoreboard bench for demux_8_stream. The reference model is one queue per
// lane: an accepted word is appended to its lane, a drained word is removed
// from the front. Lane state, occupancy, busy and in_ready all follow from
// queue sizes. Inputs change 1ns after the rising edge; the monitor checks
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_demux_8_stream;
   import demux_8_stream_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;

   logic [WIDTH-1:0] q [LANES][$];

   demux_8_stream_if bus ();

   demux_8_stream dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] lane_word(input int i);
      return bus.out_data[i*WIDTH +: WIDTH];
   endfunction

   // One clock of stimulus; the expected lane content is queued once inputs
   // are stable, after the monitor has retired this cycle's drains.
   task automatic cyc(input logic v, input logic [SEL_W-1:0] sel, input logic [WIDTH-1:0] d,
                      input logic [LANES-1:0] rdy, output logic acc);
      @(posedge clock);
      #1;
      bus.in_valid  = v;
      bus.in_select = sel;
      bus.in_data   = d;
      bus.out_ready = rdy;
      #5;
      acc = v && (q[sel].size() == 0 || rdy[sel]);
      if (acc) q[sel].push_back(d);
   endtask

   // Idle cycle, then walk in_select with in_valid low and out_ready low so
   // lane state cannot change while in_ready is probed.
   task automatic sweep(input logic [LANES-1:0] exp_mask, input string nm);
      logic a;
      cyc(1'b0, '0, '0, '0, a);
      for (int s = 0; s < LANES; s++) begin
         bus.in_select = SEL_W'(s);
         #1;
         chk(nm, bus.in_ready, exp_mask[s]);
      end
   endtask

   // Monitor / scoreboard
   initial begin
      int n;
      forever begin
         @(negedge clock);
         if (reset) begin
            n = 0;
            for (int i = 0; i < LANES; i++) begin
               chk("mon_valid", bus.out_valid[i], q[i].size() > 0);
               if (q[i].size() > 0) chk("mon_data", lane_word(i), q[i][0]);
               n += q[i].size();
            end
            chk("mon_occupancy", bus.occupancy, n);
            chk("mon_busy", bus.busy, n > 0);
            chk("mon_in_ready", bus.in_ready,
                q[bus.in_select].size() == 0 || bus.out_ready[bus.in_select]);
            for (int i = 0; i < LANES; i++) begin
               if (bus.out_ready[i] && q[i].size() > 0) void'(q[i].pop_front());
            end
         end
      end
   end

   // Stimulus
   initial begin
      logic             acc;
      logic             pv;
      logic [SEL_W-1:0] ps;
      logic [WIDTH-1:0] pd;

      bus.in_valid  = 1'b0;
      bus.in_select = '0;
      bus.in_data   = '0;
      bus.out_ready = '0;
      #1;
      chk("reset_valid", bus.out_valid, 8'h00);
      chk("reset_data", bus.out_data[63:0], 64'h0);
      chk("reset_occupancy", bus.occupancy, 0);
      chk("reset_busy", bus.busy, 0);
      @(posedge clock);
      #1;
      reset = 1'b1;

      // Reset in the middle of traffic
      cyc(1'b1, 3'd2, 32'hAAAA0002, 8'h00, acc);
      cyc(1'b1, 3'd5, 32'hAAAA0005, 8'h00, acc);
      cyc(1'b0, 3'd0, 32'h0, 8'h00, acc);
      chk("pre_reset_valid", bus.out_valid, 8'h24);
      #2;
      reset = 1'b0;
      #1;
      chk("async_reset_valid", bus.out_valid, 8'h00);
      chk("async_reset_occupancy", bus.occupancy, 0);
      chk("async_reset_busy", bus.busy, 0);
      for (int i = 0; i < LANES; i++) q[i].delete();
      bus.in_valid  = 1'b0;
      bus.out_ready = '0;
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b1;
      for (int s = 0; s < LANES; s++) begin
         bus.in_select = SEL_W'(s);
         #1;
         chk("post_reset_in_ready", bus.in_ready, 1);
      end

      // Single word
      cyc(1'b1, 3'd3, 32'hDEADBEEF, 8'h00, acc);
      cyc(1'b0, 3'd0, 32'h0, 8'h00, acc);
      chk("single_valid", bus.out_valid, 8'h08);
      chk("single_data", bus.out_data[127:96], 32'hDEADBEEF);
      chk("single_occupancy", bus.occupancy, 1);
      chk("single_busy", bus.busy, 1);

      // Backpressure on lane 3, then release
      cyc(1'b1, 3'd3, 32'h12345678, 8'h00, acc);
      chk("bp_in_ready_low", bus.in_ready, 0);
      cyc(1'b0, 3'd0, 32'h0, 8'h00, acc);
      chk("bp_hold_data", lane_word(3), 32'hDEADBEEF);
      cyc(1'b1, 3'd3, 32'h12345678, 8'h08, acc);
      chk("bp_in_ready_high", bus.in_ready, 1);
      cyc(1'b0, 3'd0, 32'h0, 8'h00, acc);
      chk("bp_valid_kept", bus.out_valid[3], 1);
      chk("bp_new_data", lane_word(3), 32'h12345678);

      // Streaming into lane 7 with every consumer ready
      for (int k = 1; k <= 16; k++) begin
         cyc(1'b1, 3'd7, WIDTH'(k), 8'hFF, acc);
         chk("stream_in_ready", bus.in_ready, 1);
         if (k > 1) chk("stream_lane7", lane_word(7), k - 1);
      end
      cyc(1'b0, 3'd0, 32'h0, 8'hFF, acc);

      // Fill every lane, then drain lane 4
      for (int i = 0; i < LANES; i++) cyc(1'b1, SEL_W'(i), 32'h100 + i, 8'h00, acc);
      sweep(8'h00, "full_in_ready");
      chk("full_occupancy", bus.occupancy, 8);
      cyc(1'b0, 3'd0, 32'h0, 8'h10, acc);
      sweep(8'h10, "drain4_in_ready");
      chk("drain4_occupancy", bus.occupancy, 7);

      // Accept into lane 1 while lane 6 drains
      cyc(1'b0, 3'd0, 32'h0, 8'h02, acc);
      cyc(1'b0, 3'd0, 32'h0, 8'h00, acc);
      chk("cross_pre_occupancy", bus.occupancy, 6);
      cyc(1'b1, 3'd1, 32'hABCD0001, 8'h40, acc);
      cyc(1'b0, 3'd0, 32'h0, 8'h00, acc);
      chk("cross_lane1_valid", bus.out_valid[1], 1);
      chk("cross_lane6_valid", bus.out_valid[6], 0);
      chk("cross_occupancy", bus.occupancy, 6);
      chk("cross_lane1_data", lane_word(1), 32'hABCD0001);

      // Random traffic; a refused word is held until it is taken
      acc = 1'b1;
      pv  = 1'b0;
      ps  = '0;
      pd  = '0;
      for (int n = 0; n < 400; n++) begin
         if (!(pv && !acc)) begin
            pv = ($urandom_range(0, 3) != 0);
            ps = SEL_W'($urandom_range(0, LANES - 1));
            pd = $urandom;
         end
         cyc(pv, ps, pd, LANES'($urandom), acc);
      end
      cyc(1'b0, 3'd0, 32'h0, 8'hFF, acc);
      cyc(1'b0, 3'd0, 32'h0, 8'h00, acc);
      chk("final_occupancy", bus.occupancy, 0);
      chk("final_busy", bus.busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
